// File: rtl/arp_pkg.sv
// Shared constants, state type and frame builder for the ARP transmit path.
package arp_pkg;

   localparam int unsigned ARP_LENGTH = 28;
   localparam int unsigned FRAME_W    = ARP_LENGTH * 8;

   localparam logic [15:0] HTYPE      = 16'h0001;
   localparam logic [15:0] PTYPE      = 16'h0800;
   localparam logic [7:0]  HLEN       = 8'h06;
   localparam logic [7:0]  PLEN       = 8'h04;
   localparam logic [15:0] OP_REQUEST = 16'h0001;
   localparam logic [15:0] OP_REPLY   = 16'h0002;

   typedef enum logic [1:0] {IDLE, SEND, ACK} arp_state_e;

   // Byte 0 of the frame lands in the most significant byte of the result.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [15:0] oper,
                                                      input logic [47:0] sha,
                                                      input logic [31:0] spa,
                                                      input logic [47:0] tha,
                                                      input logic [31:0] tpa);
      return {HTYPE, PTYPE, HLEN, PLEN, oper, sha, spa, tha, tpa};
   endfunction

endpackage

// File: rtl/arp_send_if.sv
// Byte stream from the ARP transmitter toward the MAC framing stage.
interface arp_send_if;

   logic [7:0] arp_tdata_out;
   logic       arp_tvalid_out;
   logic       arp_tlast_out;
   logic       arp_tready_in;

   modport master (
      output arp_tdata_out,
      output arp_tvalid_out,
      output arp_tlast_out,
      input  arp_tready_in
   );

   modport slave (
      input  arp_tdata_out,
      input  arp_tvalid_out,
      input  arp_tlast_out,
      output arp_tready_in
   );

endinterface

// File: rtl/arp_send.sv
// ARP transmitter: snapshots a 28-byte reply or request payload and streams it
// MSB-first, then holds a level acknowledge for replies.
module arp_send
   import arp_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       local_ip_addr,
   input  logic [47:0]       local_mac_addr,
   input  logic [31:0]       remote_ip_addr_in,
   input  logic [47:0]       remote_mac_addr_in,
   input  logic              arp_reply_in,
   output logic              reply_ready_out,
   output logic              arp_reply_ack,
   input  logic              arp_request_in,
   input  logic [31:0]       request_ip_addr_in,
   arp_send_if.master        axis
);

   localparam logic [4:0] LastIdx = 5'(ARP_LENGTH - 1);

   arp_state_e         state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;       // byte index in SEND, ack age in ACK
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               is_reply_q, is_reply_d;
   logic               req_pend_q, req_pend_d;
   logic [31:0]        req_ip_q, req_ip_d;
   logic [FRAME_W-1:0] frame_shift;

   // State and snapshot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         frame_q    <= '0;
         is_reply_q <= 1'b0;
         req_pend_q <= 1'b0;
         req_ip_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         is_reply_q <= is_reply_d;
         req_pend_q <= req_pend_d;
         req_ip_q   <= req_ip_d;
      end
   end

   // Next-state: frame selection in IDLE, byte stepping in SEND, ack hold in ACK.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      frame_d    = frame_q;
      is_reply_d = is_reply_q;
      req_pend_d = req_pend_q;
      req_ip_d   = req_ip_q;

      unique case (state_q)
         IDLE: begin
            if (arp_reply_in) begin
               state_d    = SEND;
               cnt_d      = '0;
               is_reply_d = 1'b1;
               frame_d    = build_frame(OP_REPLY, local_mac_addr, local_ip_addr,
                                        remote_mac_addr_in, remote_ip_addr_in);
            end else if (req_pend_q) begin
               state_d    = SEND;
               cnt_d      = '0;
               is_reply_d = 1'b0;
               req_pend_d = 1'b0;
               frame_d    = build_frame(OP_REQUEST, local_mac_addr, local_ip_addr,
                                        48'h0, req_ip_q);
            end
         end
         SEND: begin
            if (axis.arp_tready_in) begin
               if (cnt_q == LastIdx) begin
                  cnt_d   = '0;
                  state_d = is_reply_q ? ACK : IDLE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         ACK: begin
            // The receiver double-syncs the ack, so keep it up for 3 cycles minimum.
            if (cnt_q >= 5'd2 && !arp_reply_in) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q < 5'd2) begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new pulse wins over the clear from loading a request frame.
      if (arp_request_in) begin
         req_pend_d = 1'b1;
         req_ip_d   = request_ip_addr_in;
      end
   end

   assign frame_shift = frame_q << {cnt_q, 3'b000};

   // Stream and status outputs decoded from the registered state.
   always_comb begin
      axis.arp_tvalid_out = (state_q == SEND);
      axis.arp_tdata_out  = (state_q == SEND) ? frame_shift[FRAME_W-1 -: 8] : 8'h00;
      axis.arp_tlast_out  = (state_q == SEND) && (cnt_q == LastIdx);
      reply_ready_out     = (state_q == IDLE);
      arp_reply_ack       = (state_q == ACK);
   end

endmodule
